async_fifo16_wr_arb: RTL
========================

// Module: async_fifo16_wr_arb
// PURPOSE
//  Round-robin write-port arbiter/scheduler for async_fifo16, write-clock side.
//  Shares the single FIFO write port (DIN/DIN_DV) among NREQ sources in bursts.
//  async_fifo16 has no full flag, so this block owns a credit counter of DEPTH entries.
//  Credits return via CRED_RET, a single-cycle pulse per FIFO word read, already in CLK domain.
// PARAMETERS
//  WIDTH      10  data word width, equal to async_fifo16 WIDTH
//  NREQ       4   number of requesters, 2..8
//  DEPTH      16  FIFO capacity in words, i.e. initial credit count
//  MAX_BURST  4   max words per grant, 1..DEPTH
// PORTS
//  CLK       in   1            write clock (async_fifo16 W_CLK); single clock for the block
//  RST       in   1            synchronous, active-high reset
//  REQ_DV    in   NREQ         per-source data valid
//  REQ_DATA  in   NREQ*WIDTH   per-source data; source k at [k*WIDTH +: WIDTH]
//  REQ_RDY   out  NREQ         per-source ready; a word moves when REQ_DV[k] & REQ_RDY[k]
//  CRED_RET  in   1            one FIFO word consumed; returns one credit
//  DIN       out  WIDTH        to async_fifo16 DIN
//  DIN_DV    out  1            to async_fifo16 DIN_DV
//  GNT_ID    out  clog2(NREQ)  currently/last granted source
//  CREDITS   out  clog2(DEPTH+1)  free FIFO entries
//  OVF_ERR   out  1            one-cycle pulse on credit overflow
// BEHAVIOUR
//  Reset: DIN=0, DIN_DV=0, REQ_RDY=0, GNT_ID=0, CREDITS=DEPTH, OVF_ERR=0, state=IDLE,
//   last_grant=NREQ-1 (so source 0 wins first), beat_cnt=0. RST mid-burst aborts the burst.
//   The data already written is dropped; the FIFO must be reset in the same cycle.
//  FSM IDLE -> BURST -> GAP -> IDLE:
//   IDLE:  if |REQ_DV and CREDITS>0, pick the first k with REQ_DV[k] searching last_grant+1 upward.
//          The search wraps modulo NREQ. Latch GNT_ID=k, beat_cnt=0, go BURST. Otherwise stay IDLE.
//   BURST: REQ_RDY[GNT_ID] = (CREDITS>0) & (beat_cnt<MAX_BURST); all other REQ_RDY bits are 0.
//          REQ_RDY is combinational from registered state only, never from REQ_DV.
//          On each transfer, beat_cnt++.
//          Leave to GAP when any of these holds:
//            - a transfer makes beat_cnt==MAX_BURST;
//            - REQ_DV[GNT_ID]==0;
//            - CREDITS is 0, counting this cycle's decrement and return.
//          On leaving, last_grant=GNT_ID.
//   GAP:   one idle cycle, REQ_RDY=0, then IDLE. Minimum bubble between bursts is 2 cycles.
//  Datapath: latency 1. The cycle after a transfer: DIN=REQ_DATA[GNT_ID], DIN_DV=1.
//   Otherwise DIN_DV=0 and DIN holds its last value.
//  Credits, all in one cycle: CREDITS_next = CREDITS - xfer + CRED_RET.
//   - Simultaneous xfer and CRED_RET leaves it unchanged.
//   - xfer is only possible when CREDITS>0, so there is no underflow.
//   - CRED_RET with CREDITS==DEPTH and no xfer: saturate at DEPTH, OVF_ERR=1 next cycle.
//  A source dropping REQ_DV mid-burst forfeits the rest of its grant; no re-grant until its turn.
//  Fairness: with all NREQ sources valid and credits available, grants rotate 0,1,..,NREQ-1,0.
//  All outputs are registered except REQ_RDY.
// STRUCTURE
//  async_lib_defs.vh: FSM state localparams (IDLE=2'd0, BURST=2'd1, GAP=2'd2).
//   The same file holds the clog2 helper macro.
//  Sub-module rr_arbiter #(NREQ): combinational rotating-priority picker.
//   Inputs: req vector, last_grant. Outputs: gnt_id, gnt_valid. Reusable by the read side.
//  Top holds the FSM, beat counter, credit counter and output registers.
// TESTING
//  1. Reset, then REQ_DV=4'b0001 with 6 words.
//     -> Burst of 4 words (DIN_DV high 4 cycles, 1 cycle after each RDY).
//     -> 2-cycle bubble, then a burst of 2. CREDITS 16->10.
//  2. All 4 sources valid continuously, CRED_RET each cycle.
//     -> GNT_ID sequence 0,1,2,3,0.
//     -> Each burst is exactly 4 words. CREDITS stays at 16.
//  3. No CRED_RET, source 0 always valid.
//     -> Exactly 16 words written, then REQ_RDY stays 0 and CREDITS=0.
//     -> One CRED_RET pulse -> exactly 1 more word.
//  4. Simultaneous xfer and CRED_RET at CREDITS=1 -> CREDITS stays 1, the burst continues.
//     CRED_RET at CREDITS=16 -> CREDITS stays 16, OVF_ERR pulses for 1 cycle.
//  5. RST asserted in the 2nd beat of a burst -> next cycle: DIN_DV=0, REQ_RDY=0, CREDITS=16.
//     -> The following grant goes to source 0.
//  6. Source 2 drops REQ_DV after 1 beat with sources 2 and 3 valid.
//     -> Burst ends, GAP, then source 3 is granted.
//  Scoreboard: per-source word order preserved on DIN; no DIN_DV while CREDITS==0 last cycle.

Source files
------------

// File: rtl/async_fifo16_wr_arb_pkg.sv
// Shared types and helpers for the async_fifo16 write-side arbiter.
package async_fifo16_wr_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBurst = 2'd1,
    StGap   = 2'd2
  } arb_state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first requester after last_grant, wrapping.
module rr_arbiter
  import async_fifo16_wr_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid
);

  int idx;

  // Scan from farthest to nearest so the nearest hit after last_grant wins.
  always_comb begin
    gnt_id    = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int i = int'(NREQ); i >= 1; i--) begin
      idx = (int'(last_grant) + i) % int'(NREQ);
      if (req[idx]) begin
        gnt_id    = IDW'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/async_fifo16_wr_arb.sv
// Round-robin burst scheduler for the async_fifo16 write port, with credit-based flow control.
module async_fifo16_wr_arb
  import async_fifo16_wr_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NREQ-1:0]                 REQ_DV,
  input  logic [NREQ*WIDTH-1:0]           REQ_DATA,
  output logic [NREQ-1:0]                 REQ_RDY,
  input  logic                            CRED_RET,
  output logic [WIDTH-1:0]                DIN,
  output logic                            DIN_DV,
  output logic [clog2_min1(NREQ)-1:0]     GNT_ID,
  output logic [$clog2(DEPTH+1)-1:0]      CREDITS,
  output logic                            OVF_ERR
);

  localparam int unsigned IdW = clog2_min1(NREQ);
  localparam int unsigned CrW = $clog2(DEPTH + 1);
  localparam int unsigned BcW = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [IdW-1:0]   gnt_q, gnt_d;
  logic [IdW-1:0]   last_q, last_d;
  logic [BcW-1:0]   beat_q, beat_d;
  logic [CrW-1:0]   cred_q, cred_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             dv_q, dv_d;
  logic             ovf_q, ovf_d;

  logic [IdW-1:0]   arb_id;
  logic             arb_valid;
  logic             rdy_gnt;
  logic             xfer;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IdW)
  ) u_rr_arbiter (
    .req        (REQ_DV),
    .last_grant (last_q),
    .gnt_id     (arb_id),
    .gnt_valid  (arb_valid)
  );

  assign rdy_gnt = (state_q == StBurst) && (cred_q != '0) && (beat_q < BcW'(MAX_BURST));
  assign xfer    = rdy_gnt && REQ_DV[gnt_q];

  always_comb begin
    REQ_RDY        = '0;
    REQ_RDY[gnt_q] = rdy_gnt;
  end

  // A return with the counter already full and nothing leaving is a protocol error.
  always_comb begin
    cred_d = cred_q;
    ovf_d  = 1'b0;
    if (xfer && !CRED_RET) begin
      cred_d = cred_q - CrW'(1);
    end else if (!xfer && CRED_RET) begin
      if (cred_q == CrW'(DEPTH)) ovf_d = 1'b1;
      else                       cred_d = cred_q + CrW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    beat_d  = beat_q;
    din_d   = din_q;
    dv_d    = xfer;
    if (xfer) din_d = REQ_DATA[gnt_q*WIDTH +: WIDTH];
    case (state_q)
      StIdle: begin
        if (arb_valid && cred_q != '0) begin
          gnt_d   = arb_id;
          beat_d  = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (xfer) beat_d = beat_q + BcW'(1);
        if ((xfer && (beat_q + BcW'(1) == BcW'(MAX_BURST))) || !REQ_DV[gnt_q] ||
            (cred_d == '0)) begin
          state_d = StGap;
          last_d  = gnt_q;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= IdW'(NREQ - 1);
      beat_q  <= '0;
      cred_q  <= CrW'(DEPTH);
      din_q   <= '0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      cred_q  <= cred_d;
      din_q   <= din_d;
      dv_q    <= dv_d;
      ovf_q   <= ovf_d;
    end
  end

  assign DIN     = din_q;
  assign DIN_DV  = dv_q;
  assign GNT_ID  = gnt_q;
  assign CREDITS = cred_q;
  assign OVF_ERR = ovf_q;

endmodule
